ysyx_22050019_wb_arb: RTL
=========================

Name: ysyx_22050019_wb_arb

Overview:
Write-back arbiter that acts as the writer side of the general-purpose register file. It collects completed results from the EXU (ALU) and LSU (loads) over valid/ready handshakes and buffers them in a small in-order queue. It then drives the register file's single write port with at most one write per cycle. It also reports pending-write hazards for the two read addresses and exposes the committing PC and a retire counter for difftest.

Parameters:
ADDR_WIDTH, 5, register index width
DATA_WIDTH, 64, data and PC width
DEPTH, 4, queue entries; power of two, >= 2

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
exu_valid  in  1  EXU result valid
exu_ready  out  1  EXU result accepted this cycle
exu_waddr  in  ADDR_WIDTH  EXU destination register
exu_wdata  in  DATA_WIDTH  EXU result
exu_pc  in  DATA_WIDTH  PC of the EXU instruction
lsu_valid  in  1  LSU load result valid
lsu_ready  out  1  LSU result accepted this cycle
lsu_waddr  in  ADDR_WIDTH  LSU destination register
lsu_wdata  in  DATA_WIDTH  load data
lsu_pc  in  DATA_WIDTH  PC of the load
wb_stall  in  1  hold: no pop from the queue this cycle
wen  out  1  register file write enable (registered)
waddr  out  ADDR_WIDTH  register file write index (registered)
wdata  out  DATA_WIDTH  register file write data (registered)
now_pc  out  DATA_WIDTH  PC of the most recently retired entry (registered)
retire_cnt  out  64  count of retired entries
raddr1  in  ADDR_WIDTH  hazard query, read port 1
raddr2  in  ADDR_WIDTH  hazard query, read port 2
busy1  out  1  a pending write targets raddr1
busy2  out  1  a pending write targets raddr2

Behaviour:
- Reset (async, rst_n=0): queue empty, rd/wr pointers 0, count 0; wen=0, waddr=0, wdata=0, now_pc=0, retire_cnt=0. All state is cleared immediately, including entries in flight; the pending write is dropped.
- Queue: circular, DEPTH entries of {waddr, wdata, pc}. Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits wide. full = (count==DEPTH). empty = (count==0).
- Accept rules (combinational from current state):
  - lsu_ready = !full.
  - exu_ready = !full && !lsu_valid. LSU has fixed priority.
  - A push happens when the granted source is valid and ready. At most one push per cycle.
- full is evaluated on the pre-pop count. A pop in the same cycle does not open a slot for a push in that cycle.
- Pop: when !empty && !wb_stall, the head is popped at the clock edge and the output registers load as follows:
  - wen = (head.waddr != 0)
  - waddr = head.waddr
  - wdata = head.wdata
  - now_pc = head.pc
  - retire_cnt increments by 1
- No pop in a cycle: wen=0 next cycle; waddr, wdata and now_pc hold.
- wen is high for exactly one cycle per popped entry with a nonzero index.
- x0 entries: they are accepted, popped, update now_pc and increment retire_cnt, but never assert wen.
- Latency: a handshake at edge N puts the entry in the queue. If the entry is at the head with no stall, it pops at edge N+1. wen is high from N+1 to N+2, and the register file writes at edge N+2.
- Ordering: entries retire strictly in acceptance order.
- Simultaneous push and pop (non-full): count is unchanged and both pointers advance.
- Hazard flags (combinational):
  - busy1 = (raddr1 != 0) && (a valid queue entry has waddr == raddr1, or (wen && waddr == raddr1)).
  - busy2 is defined the same way for raddr2.
  - Index 0 is never busy.
- retire_cnt wraps modulo 2^64.

Test Plan:
- Reset, then exu_valid=1 with waddr=5, wdata=0x1234, pc=0x80000000 for one cycle -> exu_ready=1; wen=1, waddr=5, wdata=0x1234, now_pc=0x80000000 two edges later; retire_cnt=1.
- exu_valid and lsu_valid both high (EXU rd=3, LSU rd=4) -> lsu_ready=1, exu_ready=0. The next cycle EXU is accepted. Writes to x4 then x3 on consecutive cycles.
- wb_stall=1 while pushing 5 EXU results -> first 4 accepted, then exu_ready=0 and lsu_ready=0. Release the stall -> 4 consecutive wen pulses in order. The fifth entry is accepted on the first pop cycle plus one.
- Push with waddr=0, wdata=0xFF -> wen stays 0; now_pc updates; retire_cnt increments; busy1=0 with raddr1=0.
- Queue holds a write to x7, raddr1=7, raddr2=8 -> busy1=1, busy2=0. busy1 stays 1 through the wen cycle and drops to 0 the cycle after.
- rst_n pulsed low with 3 entries queued and wen=1 -> wen=0 and retire_cnt=0 immediately. After release, no further writes occur and both ready outputs are 1.

Source files
------------

// File: rtl/ysyx_22050019_wb_arb_if.sv
// Bundle of the write-back arbiter's EXU/LSU result handshakes, register file
// write port and hazard query lines.
interface ysyx_22050019_wb_arb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
);
    logic                  exu_valid;
    logic                  exu_ready;
    logic [ADDR_WIDTH-1:0] exu_waddr;
    logic [DATA_WIDTH-1:0] exu_wdata;
    logic [DATA_WIDTH-1:0] exu_pc;

    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_waddr;
    logic [DATA_WIDTH-1:0] lsu_wdata;
    logic [DATA_WIDTH-1:0] lsu_pc;

    logic                  wb_stall;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] now_pc;
    logic [63:0]           retire_cnt;

    logic [ADDR_WIDTH-1:0] raddr1;
    logic [ADDR_WIDTH-1:0] raddr2;
    logic                  busy1;
    logic                  busy2;

    // Arbiter side
    modport slave (
        input  exu_valid, exu_waddr, exu_wdata, exu_pc,
        output exu_ready,
        input  lsu_valid, lsu_waddr, lsu_wdata, lsu_pc,
        output lsu_ready,
        input  wb_stall,
        output wen, waddr, wdata, now_pc, retire_cnt,
        input  raddr1, raddr2,
        output busy1, busy2
    );

    // Pipeline / environment side
    modport master (
        output exu_valid, exu_waddr, exu_wdata, exu_pc,
        input  exu_ready,
        output lsu_valid, lsu_waddr, lsu_wdata, lsu_pc,
        input  lsu_ready,
        output wb_stall,
        input  wen, waddr, wdata, now_pc, retire_cnt,
        output raddr1, raddr2,
        input  busy1, busy2
    );
endinterface

// File: rtl/ysyx_22050019_wb_arb.sv
// Write-back arbiter: in-order queue of EXU/LSU results feeding the single
// register file write port, with pending-write hazard flags and retire count.
module ysyx_22050019_wb_arb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ysyx_22050019_wb_arb_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] waddr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [DATA_WIDTH-1:0] pc;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] now_pc_q, now_pc_d;
    logic [63:0]           retire_cnt_q, retire_cnt_d;

    logic   full, empty, push, pop, push_lsu, exu_ready;
    entry_t push_entry, head;

    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        // LSU wins a simultaneous offer; a same-cycle pop never frees a slot
        exu_ready = !full && !bus.lsu_valid;
        push_lsu  = bus.lsu_valid && !full;
        push      = push_lsu || (bus.exu_valid && exu_ready);
        pop       = !empty && !bus.wb_stall;
        head      = mem_q[rd_ptr_q];

        push_entry = push_lsu ? entry_t'{bus.lsu_waddr, bus.lsu_wdata, bus.lsu_pc}
                              : entry_t'{bus.exu_waddr, bus.exu_wdata, bus.exu_pc};

        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        wen_d        = pop && (head.waddr != '0);
        waddr_d      = pop ? head.waddr : waddr_q;
        wdata_d      = pop ? head.wdata : wdata_q;
        now_pc_d     = pop ? head.pc    : now_pc_q;
        retire_cnt_d = retire_cnt_q + {63'd0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            now_pc_q     <= '0;
            retire_cnt_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            now_pc_q     <= now_pc_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Payload storage needs no reset: only slots inside [rd_ptr, rd_ptr+count) are ever observed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    logic [DEPTH-1:0] hit1, hit2;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
            logic [PTR_W-1:0] offset;
            logic             live;
            assign offset   = PTR_W'(gi) - rd_ptr_q;
            assign live     = ({1'b0, offset} < count_q);
            assign hit1[gi] = live && (mem_q[gi].waddr == bus.raddr1);
            assign hit2[gi] = live && (mem_q[gi].waddr == bus.raddr2);
        end
    endgenerate

    assign bus.exu_ready  = exu_ready;
    assign bus.lsu_ready  = !full;
    assign bus.wen        = wen_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.now_pc     = now_pc_q;
    assign bus.retire_cnt = retire_cnt_q;
    assign bus.busy1      = (bus.raddr1 != '0) && ((|hit1) || (wen_q && (waddr_q == bus.raddr1)));
    assign bus.busy2      = (bus.raddr2 != '0) && ((|hit2) || (wen_q && (waddr_q == bus.raddr2)));
endmodule
